// File: rtl/gb_initiator_if.sv
// Command/response streams plus ghostbus signals of the ghostbus host.
// The master modport is the host's view; slave is the view of the command source and the bus.
interface gb_initiator_if #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int LW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic          busy;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_wen;
    logic [DW-1:0] gb_rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, rsp_ready, gb_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_last, busy, gb_addr, gb_wdata, gb_wen
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, rsp_ready, gb_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_last, busy, gb_addr, gb_wdata, gb_wen
    );
endinterface

// File: rtl/gb_initiator.sv
// Ghostbus host: turns a valid/ready command stream into single writes or
// auto-incrementing read bursts, returning read data on a valid/ready response stream.
module gb_initiator #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2,   // legal 1..15
    parameter int LW     = 8
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    gb_initiator_if.master bus,
    output logic [1:0]    state_dbg
);
    // Handshakes: a transfer happens on the rising gb_clk edge where valid and
    // ready are both high; valid and its payload are held until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

    state_t        state;
    logic [LW-1:0] beat_cnt;
    logic [3:0]    wait_cnt;

    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
            bus.gb_addr   <= '0;
            bus.gb_wdata  <= '0;
            bus.gb_wen    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.gb_addr <= bus.cmd_addr;
                        beat_cnt    <= bus.cmd_len;
                        if (bus.cmd_we) begin
                            bus.gb_wdata <= bus.cmd_wdata;
                            bus.gb_wen   <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= RWAIT;
                        end
                    end
                end
                WRITE: begin
                    bus.gb_wen <= 1'b0;
                    state      <= IDLE;
                end
                RWAIT: begin
                    // gb_rdata is sampled RD_LAT edges after gb_addr moved
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        bus.rsp_rdata <= bus.gb_rdata;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_last  <= (beat_cnt == '0);
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        if (bus.rsp_last) begin
                            state <= IDLE;
                        end else begin
                            bus.gb_addr <= bus.gb_addr + AW'(1);
                            beat_cnt    <= beat_cnt - LW'(1);
                            wait_cnt    <= WAIT_INIT;
                            state       <= RWAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cmd_ready drops the moment reset asserts, not on the next edge
    assign bus.cmd_ready = (state == IDLE) && !gb_rst;
    assign bus.busy      = (state != IDLE);
    assign state_dbg     = state;
endmodule
